// File: rtl/commit_trace_buffer.sv
// Retire-trace FIFO: captures one record per retired instruction and presents it show-ahead
// to a valid/ready trace drain, throttling the core or dropping (and counting) when full.
module commit_trace_buffer #(
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 4,
    parameter int AFULL_LVL  = 14,
    parameter bit STALL_MODE = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              system_ena,
    input  logic              wb_valid,
    input  logic [31:0]       wb_pc,
    input  logic [31:0]       wb_instr,
    input  logic              wb_rf_we,
    input  logic [4:0]        wb_rf_waddr,
    input  logic [31:0]       wb_rf_wdata,
    output logic              trace_valid,
    input  logic              trace_ready,
    output logic [31:0]       trace_seq,
    output logic [31:0]       trace_pc,
    output logic [31:0]       trace_instr,
    output logic              trace_we,
    output logic [4:0]        trace_waddr,
    output logic [31:0]       trace_wdata,
    output logic [ADDR_W:0]   count,
    output logic              stall_req,
    output logic              overflow,
    output logic [15:0]       drop_cnt
);

    typedef struct packed {
        logic [31:0] seq;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } rec_t;

    localparam logic [ADDR_W:0]   FULL_CNT  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   AFULL_CNT = (ADDR_W+1)'(AFULL_LVL);
    localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

    rec_t              mem_q [DEPTH];
    rec_t              wr_rec;
    rec_t              head_rec;

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [31:0]       seq_q, seq_d;
    logic              stall_q, stall_d;
    logic              overflow_q, overflow_d;
    logic [15:0]       drop_cnt_q, drop_cnt_d;

    logic              retire;
    logic              full;
    logic              not_empty;
    logic              push;
    logic              pop;
    logic              drop;
    logic              keep_we;

    always_comb begin
        retire    = system_ena & wb_valid;
        full      = (count_q == FULL_CNT);
        not_empty = (count_q != '0);
        pop       = system_ena & not_empty & trace_ready;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push      = retire & (~full | pop);
        drop      = retire & full & ~pop;
    end

    // Writes to $0 and non-writing instructions are normalised so the drain sees a clean GPR field.
    always_comb begin
        keep_we        = wb_rf_we & (wb_rf_waddr != 5'd0);
        wr_rec.seq     = seq_q;
        wr_rec.pc      = wb_pc;
        wr_rec.instr   = wb_instr;
        wr_rec.we      = keep_we;
        wr_rec.waddr   = keep_we ? wb_rf_waddr : 5'd0;
        wr_rec.wdata   = keep_we ? wb_rf_wdata : 32'd0;
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        seq_d      = seq_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // Dropped records still consume a sequence number so gaps reveal the loss.
        if (retire) begin
            seq_d = seq_q + 32'd1;
        end

        if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != 16'hFFFF) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end

        stall_d = STALL_MODE & (count_d >= AFULL_CNT);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            seq_q      <= '0;
            stall_q    <= 1'b0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            seq_q      <= seq_d;
            stall_q    <= stall_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Record storage carries no reset; the pointers and count decide what is live.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            mem_q[wr_ptr_q] <= wr_rec;
        end
    end

    always_comb begin
        head_rec    = mem_q[rd_ptr_q];
        trace_valid = not_empty;
        trace_seq   = head_rec.seq;
        trace_pc    = head_rec.pc;
        trace_instr = head_rec.instr;
        trace_we    = head_rec.we;
        trace_waddr = head_rec.waddr;
        trace_wdata = head_rec.wdata;
        count       = count_q;
        stall_req   = stall_q;
        overflow    = overflow_q;
        drop_cnt    = drop_cnt_q;
    end

endmodule
